note_sequencer: RTL

Parametrised chart sequencer: holds a song of NUM_LANES note lanes × SONG_LEN columns, advances one column per `step` pulse and exposes a WINDOW-column look-ahead per lane to the square drawer and the head column to player control. Adds serial chart loading, start/pause/clear control, loop mode, per-note hit masking and end-of-song reporting. Sits between the song-speed tick generator and `square_info` / `player_control` in `tatsujin`.

---
 rtl/tatsujin_pkg.sv | 17 +
 rtl/lane_shift_reg.sv | 41 ++++
 rtl/note_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tatsujin_pkg.sv
// Shared types and constants for the tatsujin chart playback path.
package tatsujin_pkg;

    // Sequencer state; encodings are visible on the note_sequencer state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Lane indices into the lane-packed buses.
    localparam int LANE_BLUE   = 0;
    localparam int LANE_YELLOW = 1;
    localparam int LANE_RED    = 2;

endpackage

// File: rtl/lane_shift_reg.sv
// One note lane: SONG_LEN-bit chart storage with serial load, step shift and
// look-ahead window. Bit SONG_LEN-1 is the head column.
module lane_shift_reg #(
    parameter int SONG_LEN = 100,
    parameter int WINDOW   = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load_en,
    input  logic              load_bit,
    input  logic              step_en,
    input  logic              loop_mode,
    output logic [WINDOW-1:0] window,
    output logic              head
);

    logic [SONG_LEN-1:0] notes;
    logic                fill_bit;

    // Fill for the vacated tail column: the departing head when looping, else empty.
    always_comb begin
        fill_bit = loop_mode & notes[SONG_LEN-1];
    end

    // Chart storage: zeroed on reset/flush, shifted by loads and by steps.
    always_ff @(posedge clock) begin
        // NOTE: the storage is a plain register, so it is zeroed on reset like any other state.
        if (reset || flush) begin
            notes <= '0;
        end else if (load_en) begin
            notes <= {notes[SONG_LEN-2:0], load_bit};
        end else if (step_en) begin
            notes <= {notes[SONG_LEN-2:0], fill_bit};
        end
    end

    assign head   = notes[SONG_LEN-1];
    assign window = notes[SONG_LEN-1 -: WINDOW];

endmodule

// File: rtl/note_sequencer.sv
// Chart sequencer: per-lane storage, playback FSM, position counter and hit mask.
// Window and head are combinational views of the lane storage after masking.
module note_sequencer
    import tatsujin_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int SONG_LEN  = 100,
    parameter int WINDOW    = 26,
    parameter int POS_W     = $clog2(SONG_LEN + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        load_en,
    input  logic [NUM_LANES-1:0]        load_col,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        loop_mode,
    input  logic                        step,
    input  logic [NUM_LANES-1:0]        clear_hit,
    output logic [NUM_LANES*WINDOW-1:0] window,
    output logic [NUM_LANES-1:0]        head,
    output logic [POS_W-1:0]            position,
    output logic [1:0]                  state,
    output logic                        done,
    output logic                        wrap
);

    seq_state_t           st;
    logic [NUM_LANES-1:0] hit_mask;
    logic                 load_shift;
    logic                 step_fire;
    logic                 last_col;
    logic                 finish;
    logic                 flush;

    // Decode this cycle's storage actions from state and controls.
    always_comb begin
        load_shift = (st == IDLE) && load_en && !clear;
        step_fire  = (st == PLAY) && step && !pause && !clear;
        last_col   = (position == POS_W'(SONG_LEN - 1));
        finish     = step_fire && last_col && !loop_mode;
        flush      = clear || finish;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [WINDOW-1:0] lane_win;
        logic              lane_head;

        lane_shift_reg #(
            .SONG_LEN (SONG_LEN),
            .WINDOW   (WINDOW)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .load_en   (load_shift),
            .load_bit  (load_col[i]),
            .step_en   (step_fire),
            .loop_mode (loop_mode),
            .window    (lane_win),
            .head      (lane_head)
        );

        assign window[i*WINDOW +: WINDOW] =
            lane_win & ~(WINDOW'(hit_mask[i]) << (WINDOW - 1));
        assign head[i] = lane_head & ~hit_mask[i];
    end

    // Playback FSM with position counter, hit mask and done/wrap flags.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset || clear) begin
            st       <= IDLE;
            position <= '0;
            hit_mask <= '0;
            done     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        st       <= PLAY;
                        position <= '0;
                        hit_mask <= '0;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        st       <= PAUSE;
                        hit_mask <= hit_mask | clear_hit;
                    end else if (step) begin
                        // A step moves a fresh column to the head, so any judgement is dropped.
                        hit_mask <= '0;
                        if (last_col) begin
                            if (loop_mode) begin
                                position <= '0;
                                wrap     <= 1'b1;
                            end else begin
                                position <= POS_W'(SONG_LEN);
                                st       <= DONE;
                                done     <= 1'b1;
                            end
                        end else begin
                            position <= position + POS_W'(1);
                        end
                    end else begin
                        hit_mask <= hit_mask | clear_hit;
                    end
                end
                PAUSE: begin
                    hit_mask <= hit_mask | clear_hit;
                    if (!pause) begin
                        st <= PLAY;
                    end
                end
                DONE: begin
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state = st;

endmodule
